midi_voice_ctrl: RTL and testbench

Control front-end for one wavetable synthesis voice. It parses a MIDI byte stream from the UART receiver and tracks one monophonic voice with last-note priority. It drives the voice's `program`, `note_num`, `note_vel` and `env_scale` inputs, and sequences wavetable reloads through the `wtb_load`/`wtb_load_done` handshake. It sits between the MIDI UART receiver and the synthesis voice.

---
 rtl/midi_pkg.sv | 27 ++
 rtl/midi_voice_ctrl_envelope.sv | 94 +++++++++
 rtl/midi_voice_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_midi_voice_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared MIDI constants and state encodings for the voice control front-end.
package midi_pkg;

    // Status nibbles the voice reacts to
    localparam logic [3:0] NOTE_OFF  = 4'h8;
    localparam logic [3:0] NOTE_ON   = 4'h9;
    localparam logic [3:0] PROG_CHG  = 4'hC;
    // Channel pressure also carries a single data byte
    localparam logic [3:0] CHAN_PRES = 4'hD;

    // Bytes at or above this value are realtime and never disturb parsing
    localparam logic [7:0] RT_THRESH = 8'hF8;

    typedef enum logic [1:0] {
        P_IDLE,
        P_DATA1,
        P_DATA2
    } parse_state_t;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

endpackage

// File: rtl/midi_voice_ctrl_envelope.sv
// Envelope generator: free-running sample_rate divider plus AR envelope FSM.
import midi_pkg::*;

module midi_envelope #(
    parameter int unsigned ENV_DIV      = 48,
    parameter int unsigned ATTACK_STEP  = 4,
    parameter int unsigned RELEASE_STEP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_rate,
    input  logic       trig,
    input  logic       rel,
    output logic [6:0] env_scale
);

    localparam int CW = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    env_state_t    state_q, state_d;
    logic [6:0]    env_q, env_d;

    logic       tick;
    env_state_t cur_state;
    logic [7:0] sum;
    logic [7:0] diff;

    // Divider tick, note-event state override, then one envelope step per tick
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (sample_rate) begin
            if (cnt_q == CW'(ENV_DIV - 1)) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A note event picks the state first so a coincident tick steps the new state
        if (trig) begin
            cur_state = ENV_ATTACK;
        end else if (rel) begin
            cur_state = ENV_RELEASE;
        end else begin
            cur_state = state_q;
        end

        sum     = {1'b0, env_q} + 8'(ATTACK_STEP);
        diff    = {1'b0, env_q} - 8'(RELEASE_STEP);
        state_d = cur_state;
        env_d   = env_q;

        if (tick) begin
            case (cur_state)
                ENV_ATTACK: begin
                    if (sum >= 8'd127) begin
                        env_d   = 7'd127;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        env_d = sum[6:0];
                    end
                end
                ENV_SUSTAIN: env_d = 7'd127;
                ENV_RELEASE: begin
                    if (diff[7] || (diff == 8'd0)) begin
                        env_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        env_d = diff[6:0];
                    end
                end
                default: env_d = env_q;
            endcase
        end
    end

    // Divider and envelope registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= ENV_IDLE;
            env_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    assign env_scale = env_q;

endmodule

// File: rtl/midi_voice_ctrl.sv
// MIDI parser, last-note voice tracking and wavetable load sequencing.
// The program output is named program_num because "program" is a reserved word.
import midi_pkg::*;

module midi_voice_ctrl #(
    parameter logic [3:0]  MIDI_CHANNEL = 4'd0,
    parameter int unsigned ENV_DIV      = 48,
    parameter int unsigned ATTACK_STEP  = 4,
    parameter int unsigned RELEASE_STEP = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_rate,
    input  logic [7:0] midi_byte,
    input  logic       midi_byte_dv,
    output logic [6:0] program_num,
    output logic [6:0] note_num,
    output logic [6:0] note_vel,
    output logic [6:0] env_scale,
    output logic       gate,
    output logic       wtb_load,
    output logic [4:0] wtb_num,
    input  logic [4:0] wtb_load_num,
    input  logic       wtb_load_done,
    output logic       wtb_busy
);

    parse_state_t pstate_q, pstate_d;
    logic [7:0]   status_q, status_d;
    logic [6:0]   data1_q, data1_d;
    logic [6:0]   note_num_q, note_num_d;
    logic [6:0]   note_vel_q, note_vel_d;
    logic         gate_q, gate_d;
    logic [6:0]   program_q, program_d;
    logic         wtb_load_q, wtb_load_d;
    logic [4:0]   wtb_num_q, wtb_num_d;
    logic         busy_q, busy_d;
    logic [6:0]   load_prog_q, load_prog_d;
    logic [6:0]   pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;

    logic       trig, rel;
    logic       prog_evt;
    logic       ch_ok, one_byte;
    logic [3:0] st;

    // Byte parser, note tracking and loader handshake
    always_comb begin
        pstate_d     = pstate_q;
        status_d     = status_q;
        data1_d      = data1_q;
        note_num_d   = note_num_q;
        note_vel_d   = note_vel_q;
        gate_d       = gate_q;
        program_d    = program_q;
        wtb_load_d   = 1'b0;
        wtb_num_d    = wtb_num_q;
        busy_d       = busy_q;
        load_prog_d  = load_prog_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        trig         = 1'b0;
        rel          = 1'b0;
        prog_evt     = 1'b0;

        st       = status_q[7:4];
        ch_ok    = (status_q[3:0] == MIDI_CHANNEL);
        one_byte = (st == PROG_CHG) || (st == CHAN_PRES);

        if (midi_byte_dv && (midi_byte < RT_THRESH)) begin
            if (midi_byte[7]) begin
                if (midi_byte[7:4] == 4'hF) begin
                    status_d = '0;
                    pstate_d = P_IDLE;
                end else begin
                    status_d = midi_byte;
                    pstate_d = P_DATA1;
                end
            end else begin
                case (pstate_q)
                    P_DATA1: begin
                        if (one_byte) begin
                            prog_evt = (st == PROG_CHG) && ch_ok;
                        end else begin
                            data1_d  = midi_byte[6:0];
                            pstate_d = P_DATA2;
                        end
                    end
                    P_DATA2: begin
                        pstate_d = P_DATA1;
                        if (ch_ok) begin
                            if ((st == NOTE_ON) && (midi_byte[6:0] != 7'd0)) begin
                                note_num_d = data1_q;
                                note_vel_d = midi_byte[6:0];
                                gate_d     = 1'b1;
                                trig       = 1'b1;
                            end else if (((st == NOTE_ON) || (st == NOTE_OFF)) &&
                                         (data1_q == note_num_q) && gate_q) begin
                                gate_d = 1'b0;
                                rel    = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Completion is resolved before a same-cycle program change so the change
        // either issues at once or lands in the pending slot
        if (wtb_load_done && busy_q && (wtb_load_num == wtb_num_q)) begin
            program_d = load_prog_q;
            if (pend_valid_q) begin
                wtb_load_d   = 1'b1;
                wtb_num_d    = pend_q[4:0];
                load_prog_d  = pend_q;
                pend_valid_d = 1'b0;
            end else begin
                busy_d = 1'b0;
            end
        end

        if (prog_evt) begin
            if (!busy_d) begin
                wtb_load_d  = 1'b1;
                wtb_num_d   = midi_byte[4:0];
                load_prog_d = midi_byte[6:0];
                busy_d      = 1'b1;
            end else begin
                pend_d       = midi_byte[6:0];
                pend_valid_d = 1'b1;
            end
        end
    end

    // Parser, voice and loader registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pstate_q     <= P_IDLE;
            status_q     <= '0;
            data1_q      <= '0;
            note_num_q   <= '0;
            note_vel_q   <= '0;
            gate_q       <= 1'b0;
            program_q    <= '0;
            wtb_load_q   <= 1'b0;
            wtb_num_q    <= '0;
            busy_q       <= 1'b0;
            load_prog_q  <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            pstate_q     <= pstate_d;
            status_q     <= status_d;
            data1_q      <= data1_d;
            note_num_q   <= note_num_d;
            note_vel_q   <= note_vel_d;
            gate_q       <= gate_d;
            program_q    <= program_d;
            wtb_load_q   <= wtb_load_d;
            wtb_num_q    <= wtb_num_d;
            busy_q       <= busy_d;
            load_prog_q  <= load_prog_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    midi_envelope #(
        .ENV_DIV     (ENV_DIV),
        .ATTACK_STEP (ATTACK_STEP),
        .RELEASE_STEP(RELEASE_STEP)
    ) u_env (
        .clk        (clk),
        .rst        (rst),
        .sample_rate(sample_rate),
        .trig       (trig),
        .rel        (rel),
        .env_scale  (env_scale)
    );

    assign program_num = program_q;
    assign note_num    = note_num_q;
    assign note_vel    = note_vel_q;
    assign gate        = gate_q;
    assign wtb_load    = wtb_load_q;
    assign wtb_num     = wtb_num_q;
    assign wtb_busy    = busy_q;

endmodule

// File: tb/tb_midi_voice_ctrl.sv
// Directed bench for midi_voice_ctrl with hand-computed expectations.
import midi_pkg::*;

module tb_midi_voice_ctrl;

    localparam int unsigned ENV_DIV = 48;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_rate;
    logic [7:0] midi_byte;
    logic       midi_byte_dv;
    logic [6:0] program_num;
    logic [6:0] note_num;
    logic [6:0] note_vel;
    logic [6:0] env_scale;
    logic       gate;
    logic       wtb_load;
    logic [4:0] wtb_num;
    logic [4:0] wtb_load_num;
    logic       wtb_load_done;
    logic       wtb_busy;

    int n_checks = 0;
    int n_fail   = 0;

    midi_voice_ctrl #(
        .MIDI_CHANNEL(4'd0),
        .ENV_DIV     (ENV_DIV),
        .ATTACK_STEP (4),
        .RELEASE_STEP(2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_rate  (sample_rate),
        .midi_byte    (midi_byte),
        .midi_byte_dv (midi_byte_dv),
        .program_num  (program_num),
        .note_num     (note_num),
        .note_vel     (note_vel),
        .env_scale    (env_scale),
        .gate         (gate),
        .wtb_load     (wtb_load),
        .wtb_num      (wtb_num),
        .wtb_load_num (wtb_load_num),
        .wtb_load_done(wtb_load_done),
        .wtb_busy     (wtb_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".program"},   8'(program_num), 8'h00);
        check({tag, ".note_num"},  8'(note_num),    8'h00);
        check({tag, ".note_vel"},  8'(note_vel),    8'h00);
        check({tag, ".env_scale"}, 8'(env_scale),   8'h00);
        check({tag, ".gate"},      8'(gate),        8'h00);
        check({tag, ".wtb_load"},  8'(wtb_load),    8'h00);
        check({tag, ".wtb_num"},   8'(wtb_num),     8'h00);
        check({tag, ".wtb_busy"},  8'(wtb_busy),    8'h00);
    endtask

    task automatic check_env_state(input string tag, input env_state_t exp_s);
        check(tag, 8'(dut.u_env.state_q), 8'(exp_s));
    endtask

    // One-cycle byte strobe; outputs are sampled on the following negedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        midi_byte    = b;
        midi_byte_dv = 1'b1;
        @(negedge clk);
        midi_byte_dv = 1'b0;
    endtask

    // Continuous sample_rate for n whole envelope steps (keeps divider phase at 0)
    task automatic run_steps(input int n);
        @(negedge clk);
        sample_rate = 1'b1;
        repeat (n * ENV_DIV) @(negedge clk);
        sample_rate = 1'b0;
    endtask

    task automatic pulse_done(input logic [4:0] num);
        @(negedge clk);
        wtb_load_num  = num;
        wtb_load_done = 1'b1;
        @(negedge clk);
        wtb_load_done = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        sample_rate   = 1'b0;
        midi_byte     = 8'h00;
        midi_byte_dv  = 1'b0;
        wtb_load_num  = 5'd0;
        wtb_load_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check_env_state("reset.env_state", ENV_IDLE);
        rst = 1'b0;

        // Note on 60/100, then attack to the ceiling
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        check("non.note_num", 8'(note_num), 8'd60);
        check("non.note_vel", 8'(note_vel), 8'd100);
        check("non.gate", 8'(gate), 8'd1);
        check("non.env0", 8'(env_scale), 8'd0);
        check_env_state("non.env_state", ENV_ATTACK);
        run_steps(1);
        check("atk.step1", 8'(env_scale), 8'd4);
        run_steps(30);
        check("atk.step31", 8'(env_scale), 8'd124);
        check_env_state("atk.still_attack", ENV_ATTACK);
        run_steps(1);
        check("atk.step32", 8'(env_scale), 8'd127);
        check_env_state("atk.sustain", ENV_SUSTAIN);

        // Note off for a key that is not sounding
        send_byte(8'h80); send_byte(8'h3E); send_byte(8'h00);
        check("mismatch.gate", 8'(gate), 8'd1);
        check("mismatch.note", 8'(note_num), 8'd60);
        check_env_state("mismatch.env_state", ENV_SUSTAIN);

        // Realtime byte between data bytes; retrigger from current level
        send_byte(8'h90); send_byte(8'h40); send_byte(8'hF8); send_byte(8'h50);
        check("rt.note_num", 8'(note_num), 8'd64);
        check("rt.note_vel", 8'(note_vel), 8'd80);
        check("rt.env_keep", 8'(env_scale), 8'd127);
        check_env_state("rt.retrig", ENV_ATTACK);
        run_steps(1);
        check_env_state("rt.sustain", ENV_SUSTAIN);

        // Running status note on vel 0 releases
        send_byte(8'h40); send_byte(8'h00);
        check("rel.gate", 8'(gate), 8'd0);
        check("rel.vel_hold", 8'(note_vel), 8'd80);
        check_env_state("rel.state", ENV_RELEASE);
        run_steps(63);
        check("rel.step63", 8'(env_scale), 8'd1);
        run_steps(1);
        check("rel.step64", 8'(env_scale), 8'd0);
        check_env_state("rel.idle", ENV_IDLE);

        // Other channel is ignored
        send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
        check("ch1.note", 8'(note_num), 8'd64);
        check("ch1.vel", 8'(note_vel), 8'd80);
        check("ch1.gate", 8'(gate), 8'd0);

        // Program change with a newer change pending
        send_byte(8'hC0); send_byte(8'h25);
        check("pc.load", 8'(wtb_load), 8'd1);
        check("pc.num", 8'(wtb_num), 8'd5);
        check("pc.busy", 8'(wtb_busy), 8'd1);
        send_byte(8'hC0); send_byte(8'h07);
        check("pc2.noload", 8'(wtb_load), 8'd0);
        check("pc2.num_hold", 8'(wtb_num), 8'd5);
        pulse_done(5'd7);
        check("done_bad.program", 8'(program_num), 8'd0);
        check("done_bad.busy", 8'(wtb_busy), 8'd1);
        pulse_done(5'd5);
        check("done5.program", 8'(program_num), 8'h25);
        check("done5.load", 8'(wtb_load), 8'd1);
        check("done5.num", 8'(wtb_num), 8'd7);
        check("done5.busy", 8'(wtb_busy), 8'd1);
        @(negedge clk);
        check("done5.load_pulse", 8'(wtb_load), 8'd0);
        pulse_done(5'd7);
        check("done7.program", 8'(program_num), 8'd7);
        check("done7.busy", 8'(wtb_busy), 8'd0);

        // Reset during attack with a load outstanding
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        run_steps(2);
        check("pre_rst.env", 8'(env_scale), 8'd8);
        send_byte(8'hC0); send_byte(8'h0A);
        check("pre_rst.num", 8'(wtb_num), 8'd10);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midrst");
        check_env_state("midrst.env_state", ENV_IDLE);
        pulse_done(5'd10);
        check("late_done.program", 8'(program_num), 8'd0);
        check("late_done.busy", 8'(wtb_busy), 8'd0);

        // No running status after reset: lone data byte dropped
        send_byte(8'h3C); send_byte(8'h64);
        check("norun.gate", 8'(gate), 8'd0);
        check("norun.note", 8'(note_num), 8'd0);

        // Divider restarted by reset
        send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
        run_steps(1);
        check("post_rst.env", 8'(env_scale), 8'd4);

        // Matching note off via 0x8n
        send_byte(8'h80); send_byte(8'h3C); send_byte(8'h40);
        check("noteoff.gate", 8'(gate), 8'd0);
        check_env_state("noteoff.state", ENV_RELEASE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
